// File: rtl/keypad_time_entry_if.sv
// Keypad/time-entry signal bundle: row input, column drive, decoded key and loaded time.
// Latency: none, wires only.
// Backpressure: none; every output is a pulse or a level with no handshake.
// Ports: row_in (to design), col_out/key_code/key_valid/entry_digits/digit_count/
//        load_pulse/load_hour/load_min/load_sec/entry_error (from design).
interface keypad_time_entry_if;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [23:0] entry_digits;
  logic [2:0]  digit_count;
  logic        load_pulse;
  logic [5:0]  load_hour;
  logic [5:0]  load_min;
  logic [5:0]  load_sec;
  logic        entry_error;

  // master: the keypad controller, which drives the column lines and all results
  modport master (
    input  row_in,
    output col_out, key_code, key_valid, entry_digits, digit_count,
           load_pulse, load_hour, load_min, load_sec, entry_error
  );

  // slave: the keypad matrix plus whatever consumes the entered time
  modport slave (
    output row_in,
    input  col_out, key_code, key_valid, entry_digits, digit_count,
           load_pulse, load_hour, load_min, load_sec, entry_error
  );
endinterface

// File: rtl/keypad_time_entry.sv
// 4x4 keypad scanner/debouncer feeding a 6-digit HHMMSS entry buffer with range-checked load.
// Latency: key_valid DEBOUNCE_SCANS+1 scan ticks after the press is first seen; buffer/load_pulse 1 clk after key_valid.
// Backpressure: none; key_valid and load_pulse are single-cycle pulses that must be taken when offered.
// Ports: clk, RESETn (async active-low); kp.row_in in; kp.col_out, key_code, key_valid,
//        entry_digits, digit_count, load_pulse, load_hour/min/sec, entry_error out.
module keypad_time_entry #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                RESETn,
  keypad_time_entry_if.master kp
);
  localparam int            TW        = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
  localparam logic [3:0]    DB_N      = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {SCAN = 2'd0, DEBOUNCE = 2'd1, HELD = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q;
  logic [3:0]    row_s1_q, row_s2_q;
  logic [3:0]    col_q, col_d;
  logic [3:0]    cap_row_q, cap_row_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [2:0]    quiet_q, quiet_d;
  logic          armed_q, armed_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic [23:0]   buf_q, buf_d;
  logic [2:0]    count_q, count_d;
  logic          err_q, err_d;
  logic          load_q, load_d;
  logic [5:0]    hour_q, hour_d, min_q, min_d, sec_q, sec_d;

  logic       scan_tick, all_high, one_low;
  logic [3:0] rows_low;
  logic [7:0] hour_bin;
  logic [5:0] min_bin, sec_bin;
  logic       time_ok;

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] i;
    case (v)
      4'b1101: i = 2'd1;
      4'b1011: i = 2'd2;
      4'b0111: i = 2'd3;
      default: i = 2'd0;
    endcase
    return i;
  endfunction

  function automatic logic [3:0] key_of(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  assign scan_tick = (tick_q == TICK_LAST);
  assign rows_low  = ~row_s2_q;
  assign all_high  = (row_s2_q == 4'hF);
  assign one_low   = (rows_low != 4'h0) && ((rows_low & (rows_low - 4'd1)) == 4'h0);

  // Scanner FSM
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    cap_row_d   = cap_row_q;
    cnt_d       = cnt_q;
    quiet_d     = quiet_q;
    armed_d     = armed_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    if (scan_tick) begin
      case (state_q)
        SCAN: begin
          // After reset nothing is captured until one full column sweep reads
          // all rows high, so a key held through reset must be released first.
          if (!armed_q) begin
            if (!all_high)            quiet_d = 3'd0;
            else if (quiet_q == 3'd3) armed_d = 1'b1;
            else                      quiet_d = quiet_q + 3'd1;
          end
          if (armed_q && one_low) begin
            cap_row_d = row_s2_q;
            cnt_d     = 4'd0;
            state_d   = DEBOUNCE;
          end else begin
            col_d = {col_q[2:0], col_q[3]};
          end
        end
        DEBOUNCE: begin
          if (row_s2_q == cap_row_q) begin
            if (cnt_q + 4'd1 == DB_N) begin
              key_code_d  = key_of(low_idx(cap_row_q), low_idx(col_q));
              key_valid_d = 1'b1;
              cnt_d       = 4'd0;
              state_d     = HELD;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = SCAN;
          end
        end
        default: begin // HELD: cnt counts consecutive all-released samples
          if (!all_high) begin
            cnt_d = 4'd0;
          end else if (cnt_q + 4'd1 == DB_N) begin
            cnt_d   = 4'd0;
            col_d   = {col_q[2:0], col_q[3]};
            state_d = SCAN;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      endcase
    end
  end

  // Entry buffer and Enter validation, acting on the registered key pulse
  assign hour_bin = {4'h0, buf_q[23:20]} * 8'd10 + {4'h0, buf_q[19:16]};
  assign min_bin  = {2'b00, buf_q[15:12]} * 6'd10 + {2'b00, buf_q[11:8]};
  assign sec_bin  = {2'b00, buf_q[7:4]} * 6'd10 + {2'b00, buf_q[3:0]};
  assign time_ok  = (count_q == 3'd6) &&
                    (buf_q[23:20] <= 4'd9) && (buf_q[19:16] <= 4'd9) &&
                    (buf_q[15:12] <= 4'd5) && (buf_q[11:8]  <= 4'd9) &&
                    (buf_q[7:4]   <= 4'd5) && (buf_q[3:0]   <= 4'd9) &&
                    (hour_bin <= 8'd23);

  always_comb begin
    buf_d   = buf_q;
    count_d = count_q;
    err_d   = err_q;
    load_d  = 1'b0;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    if (key_valid_q) begin
      err_d = 1'b0;
      if (key_code_q <= 4'd9) begin
        if (count_q != 3'd6) begin
          buf_d   = {buf_q[19:0], key_code_q};
          count_d = count_q + 3'd1;
        end
      end else begin
        case (key_code_q)
          4'hA: begin
            if (time_ok) begin
              hour_d  = hour_bin[5:0];
              min_d   = min_bin;
              sec_d   = sec_bin;
              load_d  = 1'b1;
              buf_d   = 24'h0;
              count_d = 3'd0;
            end else begin
              err_d = 1'b1;
            end
          end
          4'hB: begin
            if (count_q != 3'd0) begin
              buf_d   = {4'h0, buf_q[23:4]};
              count_d = count_q - 3'd1;
            end
          end
          4'hC: begin
            buf_d   = 24'h0;
            count_d = 3'd0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= SCAN;
      tick_q      <= '0;
      row_s1_q    <= 4'h0;
      row_s2_q    <= 4'h0;
      col_q       <= 4'b1110;
      cap_row_q   <= 4'h0;
      cnt_q       <= 4'h0;
      quiet_q     <= 3'd0;
      armed_q     <= 1'b0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      buf_q       <= 24'h0;
      count_q     <= 3'd0;
      err_q       <= 1'b0;
      load_q      <= 1'b0;
      hour_q      <= 6'd0;
      min_q       <= 6'd0;
      sec_q       <= 6'd0;
    end else begin
      state_q     <= state_d;
      tick_q      <= scan_tick ? '0 : tick_q + 1'b1;
      row_s1_q    <= kp.row_in;
      row_s2_q    <= row_s1_q;
      col_q       <= col_d;
      cap_row_q   <= cap_row_d;
      cnt_q       <= cnt_d;
      quiet_q     <= quiet_d;
      armed_q     <= armed_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      buf_q       <= buf_d;
      count_q     <= count_d;
      err_q       <= err_d;
      load_q      <= load_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
    end
  end

  assign kp.col_out      = col_q;
  assign kp.key_code     = key_code_q;
  assign kp.key_valid    = key_valid_q;
  assign kp.entry_digits = buf_q;
  assign kp.digit_count  = count_q;
  assign kp.load_pulse   = load_q;
  assign kp.load_hour    = hour_q;
  assign kp.load_min     = min_q;
  assign kp.load_sec     = sec_q;
  assign kp.entry_error  = err_q;
endmodule

// File: tb/tb_keypad_time_entry.sv
// Testbench for keypad_time_entry: keypad matrix model, entry reference model, scenario tasks.
// Latency: n/a.
// Backpressure: n/a.
module tb_keypad_time_entry;
  localparam int SCAN_DIV = 4;
  localparam int DB       = 2;

  logic clk    = 1'b0;
  logic RESETn = 1'b0;
  always #5 clk = ~clk;

  keypad_time_entry_if kp();
  keypad_time_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .RESETn(RESETn), .kp(kp)
  );

  int checks = 0;
  int errors = 0;

  // Keypad matrix: a pressed key at (r,c) pulls row r low while column c is driven low.
  logic [15:0] pressed     = 16'h0;
  logic [3:0]  glitch_mask = 4'hF;
  logic [3:0]  rows;
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kp.col_out[c]) rows[r] = 1'b0;
    kp.row_in = rows & glitch_mask;
  end

  // Pulse monitor
  int         cyc = 0, kv_cnt = 0, lp_cnt = 0, kv_cyc = 0, lp_cyc = 0;
  logic [3:0] kv_code = 4'h0;
  always @(negedge clk) begin
    cyc++;
    if (kp.key_valid === 1'b1) begin kv_cnt++; kv_code = kp.key_code; kv_cyc = cyc; end
    if (kp.load_pulse === 1'b1) begin lp_cnt++; lp_cyc = cyc; end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model of the entry buffer: a list of digits, most significant first.
  int m_dig[$];
  bit m_err = 1'b0;
  int m_h = 0, m_m = 0, m_s = 0, m_loads = 0;

  function automatic void model_reset();
    m_dig.delete(); m_err = 1'b0; m_h = 0; m_m = 0; m_s = 0;
  endfunction

  function automatic void model_key(input int code);
    if (code <= 9) begin
      if (m_dig.size() < 6) m_dig.push_back(code);
      m_err = 1'b0;
    end else if (code == 10) begin
      if (m_dig.size() == 6 && m_dig[0]*10 + m_dig[1] <= 23 && m_dig[2] <= 5 && m_dig[4] <= 5) begin
        m_h = m_dig[0]*10 + m_dig[1];
        m_m = m_dig[2]*10 + m_dig[3];
        m_s = m_dig[4]*10 + m_dig[5];
        m_loads++;
        m_dig.delete();
        m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else if (code == 11) begin
      if (m_dig.size() > 0) void'(m_dig.pop_back());
      m_err = 1'b0;
    end else if (code == 12) begin
      m_dig.delete();
      m_err = 1'b0;
    end else begin
      m_err = 1'b0;
    end
  endfunction

  function automatic logic [23:0] model_buf();
    int v = 0;
    foreach (m_dig[i]) v = v * 16 + m_dig[i];
    return 24'(v);
  endfunction

  // Matrix position (r*4+c) of each key code
  function automatic int pos_of(input int code);
    case (code)
      1: return 0;   2: return 1;   3: return 2;   10: return 3;
      4: return 4;   5: return 5;   6: return 6;   11: return 7;
      7: return 8;   8: return 9;   9: return 10;  12: return 11;
      14: return 12; 0: return 13;  15: return 14; default: return 15;
    endcase
  endfunction

  // Press a key, hold it hold_ticks scan ticks past acceptance, release, let the buffer settle.
  task automatic press(input int code, input int hold_ticks, output int pulses, output logic [3:0] seen);
    int start, waited;
    start   = kv_cnt;
    pressed = 16'h0;
    pressed[pos_of(code)] = 1'b1;
    waited = 0;
    while (kv_cnt == start && waited < 300) begin @(negedge clk); waited++; end
    repeat (hold_ticks * SCAN_DIV) @(negedge clk);
    pressed = 16'h0;
    repeat (40) @(negedge clk);
    pulses = kv_cnt - start;
    seen   = kv_code;
    model_key(code);
  endtask

  task automatic test_reset();
    pressed = 16'h0; glitch_mask = 4'hF; RESETn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (kp.col_out !== 4'b1110) begin errors++; $display("FAIL reset_col got %b want 1110", kp.col_out); end
    checks++; if (kp.key_valid !== 1'b0 || kp.key_code !== 4'h0) begin errors++; $display("FAIL reset_key got v=%b c=%h want 0/0", kp.key_valid, kp.key_code); end
    checks++; if (kp.entry_digits !== 24'h0 || kp.digit_count !== 3'd0) begin errors++; $display("FAIL reset_buf got %h/%0d want 0/0", kp.entry_digits, kp.digit_count); end
    checks++; if (kp.load_pulse !== 1'b0 || kp.entry_error !== 1'b0) begin errors++; $display("FAIL reset_flags got lp=%b err=%b want 0/0", kp.load_pulse, kp.entry_error); end
    checks++; if ({kp.load_hour, kp.load_min, kp.load_sec} !== 18'h0) begin errors++; $display("FAIL reset_load got %0d:%0d:%0d want 0:0:0", kp.load_hour, kp.load_min, kp.load_sec); end
    RESETn = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_single_key();
    int p; logic [3:0] c;
    press(6, 2, p, c);
    checks++; if (p !== 1) begin errors++; $display("FAIL single_pulses got %0d want 1", p); end
    checks++; if (c !== 4'h6) begin errors++; $display("FAIL single_code got %h want 6", c); end
    checks++; if (kp.digit_count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", kp.digit_count); end
    checks++; if (kp.entry_digits !== 24'h000006) begin errors++; $display("FAIL single_buf got %h want 000006", kp.entry_digits); end
  endtask

  task automatic test_valid_time();
    int p, lp0, bad; logic [3:0] c;
    int seq[8] = '{12, 1, 2, 3, 4, 5, 6, 10};
    lp0 = lp_cnt; bad = 0;
    foreach (seq[i]) begin press(seq[i], 1, p, c); if (p != 1 || c != 4'(seq[i])) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL valid_keys got %0d bad presses want 0", bad); end
    checks++; if (lp_cnt - lp0 !== 1) begin errors++; $display("FAIL valid_lp_count got %0d want 1", lp_cnt - lp0); end
    checks++; if (lp_cyc !== kv_cyc + 1) begin errors++; $display("FAIL valid_lp_timing got cycle %0d want %0d", lp_cyc, kv_cyc + 1); end
    checks++; if (kp.load_hour !== 6'd12 || kp.load_min !== 6'd34 || kp.load_sec !== 6'd56) begin errors++; $display("FAIL valid_load got %0d:%0d:%0d want 12:34:56", kp.load_hour, kp.load_min, kp.load_sec); end
    checks++; if (kp.digit_count !== 3'd0 || kp.entry_digits !== 24'h0 || kp.entry_error !== 1'b0) begin errors++; $display("FAIL valid_clear got %0d/%h/%b want 0/0/0", kp.digit_count, kp.entry_digits, kp.entry_error); end
  endtask

  task automatic test_invalid_enter();
    int p, lp0; logic [3:0] c;
    int seq[7] = '{2, 4, 0, 0, 0, 0, 10};
    lp0 = lp_cnt;
    foreach (seq[i]) press(seq[i], 1, p, c);
    checks++; if (lp_cnt !== lp0) begin errors++; $display("FAIL invalid_lp got %0d pulses want 0", lp_cnt - lp0); end
    checks++; if (kp.entry_error !== 1'b1) begin errors++; $display("FAIL invalid_err got %b want 1", kp.entry_error); end
    checks++; if (kp.entry_digits !== 24'h240000) begin errors++; $display("FAIL invalid_buf got %h want 240000", kp.entry_digits); end
    checks++; if (kp.load_hour !== 6'd12) begin errors++; $display("FAIL invalid_hold got %0d want 12", kp.load_hour); end
    press(12, 1, p, c);
    checks++; if (kp.entry_digits !== 24'h0 || kp.entry_error !== 1'b0) begin errors++; $display("FAIL clear got %h/%b want 0/0", kp.entry_digits, kp.entry_error); end
  endtask

  task automatic test_backspace_saturate();
    int p; logic [3:0] c;
    int seq[3] = '{7, 8, 11};
    int more[7] = '{1, 2, 3, 4, 5, 6, 7};
    foreach (seq[i]) press(seq[i], 1, p, c);
    checks++; if (kp.entry_digits !== 24'h000007 || kp.digit_count !== 3'd1) begin errors++; $display("FAIL bksp got %h/%0d want 000007/1", kp.entry_digits, kp.digit_count); end
    foreach (more[i]) press(more[i], 1, p, c);
    checks++; if (kp.digit_count !== 3'd6) begin errors++; $display("FAIL sat_count got %0d want 6", kp.digit_count); end
    checks++; if (kp.entry_digits !== 24'h712345 || kp.entry_digits !== model_buf()) begin errors++; $display("FAIL sat_buf got %h want 712345", kp.entry_digits); end
    press(12, 1, p, c);
    press(11, 1, p, c);
    checks++; if (kp.digit_count !== 3'd0 || kp.entry_digits !== 24'h0) begin errors++; $display("FAIL bksp_empty got %h/%0d want 0/0", kp.entry_digits, kp.digit_count); end
  endtask

  task automatic test_glitch();
    int kv0, changes, bad;
    logic [3:0] prev;
    kv0 = kv_cnt;
    glitch_mask = 4'b1110;
    repeat (SCAN_DIV) @(negedge clk);
    glitch_mask = 4'hF;
    changes = 0; prev = kp.col_out;
    repeat (40) begin @(negedge clk); if (kp.col_out !== prev) changes++; prev = kp.col_out; end
    checks++; if (kv_cnt !== kv0) begin errors++; $display("FAIL glitch_kv got %0d pulses want 0", kv_cnt - kv0); end
    checks++; if (changes < 5) begin errors++; $display("FAIL glitch_rotate got %0d col changes want >=5", changes); end
    glitch_mask = 4'b1100;
    changes = 0; bad = 0; prev = kp.col_out;
    repeat (40) begin
      @(negedge clk);
      if (kp.col_out !== prev) changes++;
      prev = kp.col_out;
      if (!(kp.col_out inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) bad++;
    end
    glitch_mask = 4'hF;
    repeat (20) @(negedge clk);
    checks++; if (kv_cnt !== kv0) begin errors++; $display("FAIL tworow_kv got %0d pulses want 0", kv_cnt - kv0); end
    checks++; if (changes < 8) begin errors++; $display("FAIL tworow_rotate got %0d col changes want >=8", changes); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL col_onehot got %0d bad samples want 0", bad); end
  endtask

  task automatic test_long_hold();
    int p; logic [3:0] c;
    press(5, 50, p, c);
    checks++; if (p !== 1) begin errors++; $display("FAIL hold_pulses got %0d want 1", p); end
    checks++; if (c !== 4'h5) begin errors++; $display("FAIL hold_code got %h want 5", c); end
    checks++; if (kp.entry_digits !== model_buf()) begin errors++; $display("FAIL hold_buf got %h want %h", kp.entry_digits, model_buf()); end
  endtask

  task automatic test_reset_mid_press();
    int kv0, waited, p; logic [3:0] c;
    kv0 = kv_cnt;
    pressed = 16'h0; pressed[pos_of(9)] = 1'b1;
    waited = 0;
    while (kv_cnt == kv0 && waited < 300) begin @(negedge clk); waited++; end
    @(negedge clk);
    RESETn = 1'b0;
    model_reset();
    #1;
    checks++; if (kp.col_out !== 4'b1110 || kp.key_valid !== 1'b0 || kp.key_code !== 4'h0) begin errors++; $display("FAIL midreset_scan got col=%b v=%b c=%h want 1110/0/0", kp.col_out, kp.key_valid, kp.key_code); end
    checks++; if (kp.entry_digits !== 24'h0 || kp.digit_count !== 3'd0 || kp.load_hour !== 6'd0) begin errors++; $display("FAIL midreset_buf got %h/%0d/%0d want 0/0/0", kp.entry_digits, kp.digit_count, kp.load_hour); end
    repeat (3) @(negedge clk);
    RESETn = 1'b1;
    kv0 = kv_cnt;
    repeat (100) @(negedge clk);
    checks++; if (kv_cnt !== kv0) begin errors++; $display("FAIL midreset_nopulse got %0d pulses want 0", kv_cnt - kv0); end
    pressed = 16'h0;
    repeat (40) @(negedge clk);
    press(9, 1, p, c);
    checks++; if (p !== 1 || c !== 4'h9) begin errors++; $display("FAIL repress got %0d pulses code %h want 1/9", p, c); end
    checks++; if (kp.entry_digits !== 24'h000009) begin errors++; $display("FAIL repress_buf got %h want 000009", kp.entry_digits); end
  endtask

  task automatic test_random();
    int p, h, mi, s; logic [3:0] c;
    int seq[$];
    for (int it = 0; it < 30; it++) begin
      seq.delete();
      if ($urandom_range(0, 2) == 0) begin
        h = $urandom_range(0, 29); mi = $urandom_range(0, 69); s = $urandom_range(0, 69);
        seq.push_back(12);
        seq.push_back(h / 10);  seq.push_back(h % 10);
        seq.push_back(mi / 10); seq.push_back(mi % 10);
        seq.push_back(s / 10);  seq.push_back(s % 10);
        seq.push_back(10);
      end else begin
        seq.push_back($urandom_range(0, 15));
      end
      foreach (seq[k]) begin
        press(seq[k], $urandom_range(1, 3), p, c);
        checks++; if (p !== 1 || c !== 4'(seq[k])) begin errors++; $display("FAIL rnd_key got %0d/%h want 1/%h", p, c, 4'(seq[k])); end
        checks++; if (kp.entry_digits !== model_buf() || kp.digit_count !== 3'(m_dig.size())) begin errors++; $display("FAIL rnd_buf got %h/%0d want %h/%0d", kp.entry_digits, kp.digit_count, model_buf(), m_dig.size()); end
        checks++; if (kp.entry_error !== m_err) begin errors++; $display("FAIL rnd_err got %b want %b", kp.entry_error, m_err); end
        checks++; if (lp_cnt !== m_loads) begin errors++; $display("FAIL rnd_loads got %0d want %0d", lp_cnt, m_loads); end
        checks++; if (kp.load_hour !== 6'(m_h) || kp.load_min !== 6'(m_m) || kp.load_sec !== 6'(m_s)) begin errors++; $display("FAIL rnd_time got %0d:%0d:%0d want %0d:%0d:%0d", kp.load_hour, kp.load_min, kp.load_sec, m_h, m_m, m_s); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_valid_time();
    test_invalid_enter();
    test_backspace_saturate();
    test_glitch();
    test_long_hold();
    test_reset_mid_press();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_time_entry.md
Name: keypad_time_entry

Overview:
Scans a 4x4 matrix keypad by driving columns and reading rows. It debounces presses and decodes each key to a hex code. Digits are assembled into a 6-digit HHMMSS BCD buffer. On Enter, the buffer is range-checked and a one-cycle load pulse is issued with binary hour/min/sec, which feeds the clock or alarm counters' 6-bit load inputs.

Parameters:
SCAN_DIV, 50000, clk cycles per scan tick (column step / debounce sample); must be >= 4
DEBOUNCE_SCANS, 4, consecutive matching scan ticks needed to accept a press or a release; range 1..15

Ports:
clk  input  1  system clock (50 MHz)
RESETn  input  1  asynchronous active-low reset
row_in  input  4  keypad rows, active-low, asynchronous to clk
col_out  output  4  keypad column drive, active-low, exactly one bit low
key_code  output  4  decoded code of last accepted key
key_valid  output  1  one-cycle pulse when a key press is accepted
entry_digits  output  24  BCD buffer; [23:20]=hour tens ... [3:0]=sec ones
digit_count  output  3  digits entered, 0..6
load_pulse  output  1  one-cycle pulse when a valid time is entered
load_hour  output  6  binary hour, valid when load_pulse is high, held after
load_min  output  6  binary minute, same timing
load_sec  output  6  binary second, same timing
entry_error  output  1  high after a rejected Enter

Behaviour:
- Reset (async, RESETn=0): col_out=4'b1110; FSM=SCAN; all other outputs and internal state are 0.
- row_in passes through a 2-flop synchronizer before any use.
- A free-running tick counter produces scan_tick once every SCAN_DIV clk cycles.
- Key map (row r, column c, column c is driven by col_out[c]=0):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E, 0, F, D
- Key functions:
  - 0-9: digit
  - A: Enter
  - B: Backspace
  - C: Clear
  - D, E, F: reported on key_valid but otherwise ignored
- FSM states and transitions:
  - SCAN: on each scan_tick, sample the synced rows for the active column.
    - Exactly one row low: capture (row, col), clear the match counter, go to DEBOUNCE.
    - Otherwise: rotate col_out left by one (1110 -> 1101 -> 1011 -> 0111 -> 1110).
    - Zero or more than one row low: no key is captured.
  - DEBOUNCE: column is held. On each scan_tick:
    - Same single row still low: increment the counter. When it reaches DEBOUNCE_SCANS, set key_code, pulse key_valid for one cycle, go to HELD.
    - Any mismatch: return to SCAN with no pulse.
  - HELD: column is held; there is no auto-repeat. On each scan_tick:
    - All rows high: increment the release counter.
    - Otherwise: clear the release counter.
    - Release counter reaches DEBOUNCE_SCANS: return to SCAN and advance the column.
- Entry buffer: updated in the cycle after key_valid (latency 1).
  - Digit, count<6: buffer shifts left 4 bits, the new digit enters [3:0], count increments.
  - Digit, count=6: ignored.
  - Backspace: buffer shifts right 4 bits with zero fill, count decrements. No-op at count 0.
  - Clear: buffer=0, count=0, entry_error=0.
  - Any accepted key other than Enter clears entry_error.
- Enter validity: count=6, hour tens*10+ones <= 23, minute tens <= 5, second tens <= 5, every digit <= 9.
  - Valid: load_hour/min/sec = tens*10+ones, and load_pulse is high for the one cycle after key_valid. Buffer and count clear in the same cycle; entry_error=0.
  - Invalid: no load_pulse; entry_error=1; buffer is retained.
- load_* hold their last value until the next valid Enter.
- Reset asserted mid-press or mid-entry: immediate return to reset values; no pulse is generated after reset deasserts even if the key is still held. The key must be released and re-pressed, via SCAN, to register.

Test Plan:
- SCAN_DIV=4, DEBOUNCE_SCANS=2. Hold row1 low while col_out[2]=0 (key 6) for 4 ticks -> exactly one key_valid with key_code=6; digit_count 0->1; entry_digits=24'h000006.
- Press 1,2,3,4,5,6 then A -> load_pulse one cycle after the A key_valid; load_hour=12, load_min=34, load_sec=56; digit_count=0; entry_error=0.
- Enter 2,4,0,0,0,0 then A -> no load_pulse; entry_error=1; entry_digits=24'h240000. Then press C -> entry_digits=0, entry_error=0.
- Press 7,8 then B -> entry_digits=24'h000007, count=1. Press seven more digits -> count saturates at 6 and further digits are ignored.
- A 1-tick glitch on row0, and two rows low simultaneously -> no key_valid; col_out keeps rotating.
- Hold key 5 for 50 ticks -> single key_valid. Assert RESETn=0 while a key is held -> outputs reset, col_out=1110, and no key_valid until the key is released and pressed again.
